// File: rtl/hs_tx_pkg.sv
// Shared types for the handshake CDC source stage (hs_tx_buffer).
package hs_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } hs_tx_state_t;

  localparam int STAT_W = 32;

endpackage

// File: rtl/hs_tx_fifo.sv
// Single-clock show-ahead FIFO. The head word is always visible on head_o.
// Callers must only pulse push_i when not full and pop_i when not empty.
module hs_tx_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       used_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;

  // Storage is not reset: contents are only observable through a valid count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign used_o  = cnt_q;

endmodule

// File: rtl/hs_tx_buffer.sv
// Source-domain stage for the handshake synchroniser: buffers words and holds
// each on hs_data_o until ready cycles low then high. Option: HS_TX_STAT_EN.
module hs_tx_buffer
  import hs_tx_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic [DATA_W-1:0] hs_data_o,
  output logic              hs_val_o,
  input  logic              hs_ready_i,
  output logic [AW:0]       fifo_used_o,
  output logic              busy_o
`ifdef HS_TX_STAT_EN
  ,
  output logic [STAT_W-1:0] sent_cnt_o
`endif
);

  hs_tx_state_t      state_q, state_d;
  logic [DATA_W-1:0] hs_data_q, hs_data_d;
  logic              hs_val_q, hs_val_d;
  logic              rdy_en_q;
  logic              push, pop, load;
  logic              full, empty;
  logic [DATA_W-1:0] head;

  hs_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (push),
    .wdata_i  (data_i),
    .pop_i    (pop),
    .head_o   (head),
    .full_o   (full),
    .empty_o  (empty),
    .used_o   (fifo_used_o)
  );

  // Ready stays low through reset and rises on the first edge after release.
  assign data_ready_o = rdy_en_q && !full;
  assign push         = data_val_i && data_ready_o;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      hs_data_q <= '0;
      hs_val_q  <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_data_q <= hs_data_d;
      hs_val_q  <= hs_val_d;
      rdy_en_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty && hs_ready_i) state_d = SEND;
      SEND:      state_d = WAIT_LOW;
      WAIT_LOW:  if (!hs_ready_i) state_d = WAIT_HIGH;
      WAIT_HIGH: if (hs_ready_i)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state so hs_val_o is high exactly in SEND
  // and hs_data_o only moves on the IDLE->SEND load.
  always_comb begin
    load      = (state_q == IDLE) && !empty && hs_ready_i;
    pop       = (state_q == WAIT_HIGH) && hs_ready_i;
    hs_data_d = load ? head : hs_data_q;
    hs_val_d  = (state_d == SEND);
  end

  assign hs_data_o = hs_data_q;
  assign hs_val_o  = hs_val_q;
  assign busy_o    = (state_q != IDLE);

`ifdef HS_TX_STAT_EN
  logic [STAT_W-1:0] sent_cnt_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  sent_cnt_q <= '0;
    else if (pop)   sent_cnt_q <= sent_cnt_q + STAT_W'(1);
  end

  assign sent_cnt_o = sent_cnt_q;
`endif

endmodule

// File: tb/tb_hs_tx_buffer.sv
// Directed bench for hs_tx_buffer: latency, data hold, full, wrap order, reset.
module tb_hs_tx_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int AW     = $clog2(DEPTH);

  logic              clk;
  logic              arst_n;
  logic [DATA_W-1:0] data;
  logic              data_val;
  logic              data_ready;
  logic [DATA_W-1:0] hs_data;
  logic              hs_val;
  logic              hs_ready;
  logic [AW:0]       fifo_used;
  logic              busy;
`ifdef HS_TX_STAT_EN
  logic [31:0]       sent_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  hs_tx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .data_i       (data),
    .data_val_i   (data_val),
    .data_ready_o (data_ready),
    .hs_data_o    (hs_data),
    .hs_val_o     (hs_val),
    .hs_ready_i   (hs_ready),
    .fifo_used_o  (fifo_used),
    .busy_o       (busy)
`ifdef HS_TX_STAT_EN
    ,
    .sent_cnt_o   (sent_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the send pulse and return the word presented with it.
  task automatic wait_send(output logic [DATA_W-1:0] d);
    bit seen = 1'b0;
    d = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (hs_val === 1'b1) begin
        seen = 1'b1;
        d    = hs_data;
      end
    end
    chk("send_seen", {31'd0, seen}, 32'd1);
  endtask

  // From SEND: ready low, then high, completing the transfer (pop on last edge).
  task automatic finish_xfer();
    hs_ready = 1'b0;
    step();
    step();
    hs_ready = 1'b1;
    step();
  endtask

  task automatic push_one(input logic [DATA_W-1:0] w);
    data     = w;
    data_val = 1'b1;
    step();
    data_val = 1'b0;
  endtask

  logic [DATA_W-1:0] rx;
  bit                stable;
  bit                no_pulse;

  initial begin
    arst_n   = 1'b0;
    data     = '0;
    data_val = 1'b0;
    hs_ready = 1'b0;
    step();
    step();
    chk("rst_hs_data", 32'(hs_data), 32'h0);
    chk("rst_hs_val", 32'(hs_val), 32'h0);
    chk("rst_used", 32'(fifo_used), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(data_ready), 32'h0);
    arst_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", 32'(data_ready), 32'h0);
    step();
    chk("rel_ready", 32'(data_ready), 32'h1);

    // Single word: pulse in the second cycle after the push edge.
    hs_ready = 1'b1;
    push_one(16'hA5A5);
    chk("t1_used_push", 32'(fifo_used), 32'd1);
    chk("t1_val_early", 32'(hs_val), 32'h0);
    step();
    chk("t1_val_pulse", 32'(hs_val), 32'h1);
    chk("t1_data", 32'(hs_data), 32'hA5A5);
    chk("t1_busy", 32'(busy), 32'h1);
    step();
    chk("t1_val_single", 32'(hs_val), 32'h0);
    chk("t1_data_hold", 32'(hs_data), 32'hA5A5);
    hs_ready = 1'b0;
    step();
    chk("t1_used_wait", 32'(fifo_used), 32'd1);
    hs_ready = 1'b1;
    step();
    chk("t1_used_done", 32'(fifo_used), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'h0);

    // Data stability while the synchroniser stalls.
    push_one(16'h1234);
    push_one(16'h5678);
    chk("t2_val_first", 32'(hs_val), 32'h1);
    chk("t2_data_first", 32'(hs_data), 32'h1234);
    step();
    hs_ready = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (hs_data !== 16'h1234 || hs_val !== 1'b0) stable = 1'b0;
    end
    chk("t2_data_stable", {31'd0, stable}, 32'd1);
    chk("t2_used_stall", 32'(fifo_used), 32'd2);
    hs_ready = 1'b1;
    step();
    chk("t2_used_pop", 32'(fifo_used), 32'd1);
    chk("t2_no_back2back", 32'(hs_val), 32'h0);
    wait_send(rx);
    chk("t2_data_second", 32'(rx), 32'h5678);
    finish_xfer();
    chk("t2_used_empty", 32'(fifo_used), 32'd0);

    // Full: 8 accepted, 9th held until a pop is registered.
    hs_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_one(DATA_W'(16'h0100 + i));
    chk("t3_used_full", 32'(fifo_used), 32'd8);
    chk("t3_ready_full", 32'(data_ready), 32'h0);
    data     = 16'h0108;
    data_val = 1'b1;
    step();
    chk("t3_ninth_held", 32'(fifo_used), 32'd8);
    hs_ready = 1'b1;
    step();
    chk("t3_send_full", 32'(hs_data), 32'h0100);
    finish_xfer();
    chk("t3_used_pop_nopush", 32'(fifo_used), 32'd7);
    chk("t3_ready_after_pop", 32'(data_ready), 32'h1);
    step();
    data_val = 1'b0;
    chk("t3_ninth_taken", 32'(fifo_used), 32'd8);
    chk("t3_send_next", 32'(hs_data), 32'h0101);
    finish_xfer();
    for (int k = 2; k <= 8; k++) begin
      wait_send(rx);
      chk("t3_order", 32'(rx), 32'h0100 + 32'(k));
      finish_xfer();
    end
    chk("t3_used_drained", 32'(fifo_used), 32'd0);

    // Push on the pop edge at used=3; order across pointer wrap.
    hs_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(DATA_W'(i));
    chk("t4_used_3", 32'(fifo_used), 32'd3);
    for (int r = 0; r < 20; r++) begin
      hs_ready = 1'b1;
      wait_send(rx);
      chk("t4_order", 32'(rx), 32'(r));
      hs_ready = 1'b0;
      step();
      step();
      hs_ready = 1'b1;
      if (r + 3 < 20) begin
        data     = DATA_W'(r + 3);
        data_val = 1'b1;
      end
      step();
      data_val = 1'b0;
      chk("t4_used", 32'(fifo_used), (r + 3 < 20) ? 32'd3 : 32'(19 - r));
    end

    // Reset in WAIT_LOW discards the FIFO; nothing sent until a new push.
    push_one(16'hBEEF);
    push_one(16'hCAFE);
    chk("t5_send", 32'(hs_data), 32'hBEEF);
    step();
    chk("t5_busy_wait_low", 32'(busy), 32'h1);
    arst_n = 1'b0;
    #1;
    chk("t5_rst_val", 32'(hs_val), 32'h0);
    chk("t5_rst_used", 32'(fifo_used), 32'd0);
    chk("t5_rst_ready", 32'(data_ready), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
`ifdef HS_TX_STAT_EN
    chk("t5_rst_cnt", sent_cnt, 32'd0);
`endif
    hs_ready = 1'b0;
    step();
    arst_n = 1'b1;
    no_pulse = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (hs_val !== 1'b0) no_pulse = 1'b0;
    end
    hs_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (hs_val !== 1'b0) no_pulse = 1'b0;
    end
    chk("t5_no_pulse", {31'd0, no_pulse}, 32'd1);
    chk("t5_used_after", 32'(fifo_used), 32'd0);
    data     = 16'h7777;
    data_val = 1'b1;
    wait_send(rx);
    data_val = 1'b0;
    chk("t5_new_word", 32'(rx), 32'h7777);
    finish_xfer();

    // Counter: reset to zero, then five transfers.
    arst_n = 1'b0;
    step();
`ifdef HS_TX_STAT_EN
    chk("t6_cnt_rst", sent_cnt, 32'd0);
`endif
    arst_n = 1'b1;
    hs_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) push_one(DATA_W'(16'h0A00 + i));
    hs_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_send(rx);
      chk("t6_order", 32'(rx), 32'h0A00 + 32'(i));
      finish_xfer();
    end
    chk("t6_used", 32'(fifo_used), 32'd0);
`ifdef HS_TX_STAT_EN
    chk("t6_cnt_5", sent_cnt, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
